rat: RTL and testbench
======================

# rat

Two-wide register alias table for the rename stage. Each cycle it maps up to two instructions' architectural sources to physical tags. It assigns physical destinations from the two free registers offered by the PRF free list, and returns the displaced old mappings for the ROB. It is the consumer side of the PRF allocation interface: it drives `used_1`/`used_2` and takes `free_reg_1`/`free_reg_2`. On `flush` it restores its map from the RRAT.

## Interface
- `ARF_SIZE`, default 32: architectural registers (global define)
- `PRF_SIZE`, default 64: physical registers (global define)
- `PRF_IDX`, default 6: physical tag width (global define)
- ZERO_REG, default 31: hardwired-zero arch register; never renamed

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- inst_valid_1 / inst_valid_2  in  1  slot holds a real instruction
- dest_valid_1 / dest_valid_2  in  1  instruction writes a register
- dest_arch_1 / dest_arch_2  in  5  arch destination
- src_a_arch_1, src_b_arch_1, src_a_arch_2, src_b_arch_2  in  5  arch sources
- stall  in  1  downstream (ROB/RS) cannot accept; no rename this cycle
- flush  in  1  mispredict/exception recovery
- free_reg_1 / free_reg_2  in  `PRF_IDX`  two lowest free PRF tags from the free list
- rrat_prf_out  in  `ARF_SIZE`x`PRF_IDX`  retirement map
- used_1 / used_2  out  1  allocation strobes to the PRF
- src_a_tag_1, src_b_tag_1, src_a_tag_2, src_b_tag_2  out  `PRF_IDX`  renamed sources
- dest_tag_1 / dest_tag_2  out  `PRF_IDX`  new physical destination
- old_tag_1 / old_tag_2  out  `PRF_IDX`  previous mapping of the destination; sent to the ROB, later freed as PRF_old
- rat_map_out  out  `ARF_SIZE`x`PRF_IDX`  current map (debug / checkpoint)

## Operation
- State is `map[ARF_SIZE]`. Reset value: `map[i] = i`. This matches the PRF reset, where tags 0..ARF_SIZE-1 are not free.
- Write enables:
  - `w1 = inst_valid_1 & dest_valid_1 & dest_arch_1!=ZERO_REG & !stall & !flush`
  - `w2` is defined the same way for slot 2.
  - `used_1 = w1` and `used_2 = w2`.
- Destination tags follow the PRF allocation order:
  - `dest_tag_1 = w1 ? free_reg_1 : 0`
  - `dest_tag_2 = w2 ? (w1 ? free_reg_2 : free_reg_1) : 0`
- Slot 1:
  - `src_*_tag_1 = map[src_*_arch_1]`
  - `old_tag_1 = map[dest_arch_1]`
- Slot 2 intra-group bypass:
  - If `w1` and `src_*_arch_2 == dest_arch_1`, then `src_*_tag_2 = dest_tag_1`; otherwise `map[src_*_arch_2]`.
  - If `w1` and `dest_arch_2 == dest_arch_1`, then `old_tag_2 = dest_tag_1`; otherwise `map[dest_arch_2]`.
- Map update at posedge, in priority order:
  - `reset`: map becomes identity.
  - `flush`: `map <= rrat_prf_out` wholesale; dispatch ignored.
  - Otherwise, if `w1`: `map[dest_arch_1] <= dest_tag_1`.
  - Then, if `w2`: `map[dest_arch_2] <= dest_tag_2`. Slot 2 wins when both slots write the same dest.
- ZERO_REG sources always read `map[ZERO_REG]`, which stays at 31 unless flush loads otherwise. The RRAT never renames it.
- When not writing, `old_tag_*` outputs are don't-care in value but must be deterministic (map read).
- Free-list exhaustion is not detected here; the PRF guarantees two free tags whenever stall is low.

## Timing
- All tag outputs and `used_*` are combinational from the current map and inputs (zero-cycle rename).
- The map change is visible on outputs the cycle after the edge.
- `used_*` must be low in any cycle where `stall`, `flush`, or `reset` is high, so the PRF free list is never consumed without a matching map write.
- Flush then dispatch: the first dispatch after the flush cycle reads the restored RRAT map.
- Reset asserted mid-stream discards any same-cycle dispatch or flush; outputs reflect the identity map the next cycle.
- No multicycle paths and no handshake beyond stall.

## Test plan
- **Reset:** assert reset one cycle. Every `rat_map_out[i] == i`, and `src_a_arch_1=5` yields tag 5 with `used_*=0`.
- **Dual rename:** free 32/33, slot 1 writes r3, slot 2 writes r4.
  - `dest_tag_1=32`, `dest_tag_2=33`, `old_tag_1=3`, `old_tag_2=4`.
  - Next cycle `map[3]=32`, `map[4]=33`.
- **Intra-group bypass:** slot 1 writes r7 (free 40), slot 2 reads r7/r7 and writes r7 (free 41).
  - `src_a_tag_2=src_b_tag_2=40`, `old_tag_2=40`.
  - Next cycle `map[7]=41`.
- **Slot-1-idle allocation:** slot 1 has `dest_valid=0`, slot 2 writes r9 with free 50/51.
  - `used_1=0`, `used_2=1`, `dest_tag_2=50`.
- **ZERO_REG and stall:**
  - A write to r31 gives `used=0` and the map is unchanged.
  - With stall high and valid writes, `used_1=used_2=0` and the map is unchanged.
- **Flush:** rename r3 to 32, then assert flush with `rrat_prf_out[3]=3` and a concurrent slot 1 write to r5.
  - `used_1=0`.
  - Next cycle `map[3]=3` and `map[5]` equals the RRAT value.

Source files
------------

// File: rtl/rat_if.sv
// Rename-stage bus between the decode/dispatch side and the RAT.
// Carries per-slot arch regs, stall/flush, free tags, RRAT map and renamed tags.
interface rat_if #(
    parameter int ARF_SIZE = 32,
    parameter int PRF_SIZE = 64,
    parameter int PRF_IDX  = $clog2(PRF_SIZE),
    parameter int ARF_IDX  = $clog2(ARF_SIZE)
);
    logic                                inst_valid_1;
    logic                                inst_valid_2;
    logic                                dest_valid_1;
    logic                                dest_valid_2;
    logic [ARF_IDX-1:0]                  dest_arch_1;
    logic [ARF_IDX-1:0]                  dest_arch_2;
    logic [ARF_IDX-1:0]                  src_a_arch_1;
    logic [ARF_IDX-1:0]                  src_b_arch_1;
    logic [ARF_IDX-1:0]                  src_a_arch_2;
    logic [ARF_IDX-1:0]                  src_b_arch_2;
    logic                                stall;
    logic                                flush;
    logic [PRF_IDX-1:0]                  free_reg_1;
    logic [PRF_IDX-1:0]                  free_reg_2;
    logic [ARF_SIZE-1:0][PRF_IDX-1:0]    rrat_prf_out;

    logic                                used_1;
    logic                                used_2;
    logic [PRF_IDX-1:0]                  src_a_tag_1;
    logic [PRF_IDX-1:0]                  src_b_tag_1;
    logic [PRF_IDX-1:0]                  src_a_tag_2;
    logic [PRF_IDX-1:0]                  src_b_tag_2;
    logic [PRF_IDX-1:0]                  dest_tag_1;
    logic [PRF_IDX-1:0]                  dest_tag_2;
    logic [PRF_IDX-1:0]                  old_tag_1;
    logic [PRF_IDX-1:0]                  old_tag_2;
    logic [ARF_SIZE-1:0][PRF_IDX-1:0]    rat_map_out;

    modport master (
        output inst_valid_1, inst_valid_2, dest_valid_1, dest_valid_2,
        output dest_arch_1, dest_arch_2,
        output src_a_arch_1, src_b_arch_1, src_a_arch_2, src_b_arch_2,
        output stall, flush, free_reg_1, free_reg_2, rrat_prf_out,
        input  used_1, used_2,
        input  src_a_tag_1, src_b_tag_1, src_a_tag_2, src_b_tag_2,
        input  dest_tag_1, dest_tag_2, old_tag_1, old_tag_2, rat_map_out
    );

    modport slave (
        input  inst_valid_1, inst_valid_2, dest_valid_1, dest_valid_2,
        input  dest_arch_1, dest_arch_2,
        input  src_a_arch_1, src_b_arch_1, src_a_arch_2, src_b_arch_2,
        input  stall, flush, free_reg_1, free_reg_2, rrat_prf_out,
        output used_1, used_2,
        output src_a_tag_1, src_b_tag_1, src_a_tag_2, src_b_tag_2,
        output dest_tag_1, dest_tag_2, old_tag_1, old_tag_2, rat_map_out
    );
endinterface

// File: rtl/rat.sv
// Two-wide register alias table: zero-cycle rename of two instructions.
// Ports: clock, reset (sync, active-high), rif (rat_if.slave rename bus).
module rat #(
    parameter int ARF_SIZE = 32,
    parameter int PRF_SIZE = 64,
    parameter int PRF_IDX  = $clog2(PRF_SIZE),
    parameter int ZERO_REG = 31
) (
    input  logic  clock,
    input  logic  reset,
    rat_if.slave  rif
);
    localparam int ARF_IDX = $clog2(ARF_SIZE);
    localparam logic [ARF_IDX-1:0] ZR = ARF_IDX'(ZERO_REG);

    logic [ARF_SIZE-1:0][PRF_IDX-1:0] map_q;

    logic               go;
    logic               w1;
    logic               w2;
    logic [PRF_IDX-1:0] tag_1;
    logic [PRF_IDX-1:0] tag_2;
    logic               byp_a2;
    logic               byp_b2;
    logic               byp_o2;

    // Reset also blocks allocation so the free list is never consumed
    // by a dispatch that the map is about to discard.
    assign go = !rif.stall && !rif.flush && !reset;
    assign w1 = rif.inst_valid_1 && rif.dest_valid_1 &&
                (rif.dest_arch_1 != ZR) && go;
    assign w2 = rif.inst_valid_2 && rif.dest_valid_2 &&
                (rif.dest_arch_2 != ZR) && go;

    // Slot 2 takes the lowest free tag when slot 1 does not allocate.
    assign tag_1 = w1 ? rif.free_reg_1 : '0;
    assign tag_2 = !w2 ? '0 : (w1 ? rif.free_reg_2 : rif.free_reg_1);

    assign rif.used_1     = w1;
    assign rif.used_2     = w2;
    assign rif.dest_tag_1 = tag_1;
    assign rif.dest_tag_2 = tag_2;

    assign rif.src_a_tag_1 = map_q[rif.src_a_arch_1];
    assign rif.src_b_tag_1 = map_q[rif.src_b_arch_1];
    assign rif.old_tag_1   = map_q[rif.dest_arch_1];

    // Slot 2 must see slot 1's rename of the same group.
    assign byp_a2 = w1 && (rif.src_a_arch_2 == rif.dest_arch_1);
    assign byp_b2 = w1 && (rif.src_b_arch_2 == rif.dest_arch_1);
    assign byp_o2 = w1 && (rif.dest_arch_2 == rif.dest_arch_1);

    assign rif.src_a_tag_2 = byp_a2 ? tag_1 : map_q[rif.src_a_arch_2];
    assign rif.src_b_tag_2 = byp_b2 ? tag_1 : map_q[rif.src_b_arch_2];
    assign rif.old_tag_2   = byp_o2 ? tag_1 : map_q[rif.dest_arch_2];

    assign rif.rat_map_out = map_q;

    // Slot 2 is written last so it wins a same-destination pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARF_SIZE; i++) begin
                map_q[i] <= PRF_IDX'(i);
            end
        end else if (rif.flush) begin
            map_q <= rif.rrat_prf_out;
        end else begin
            if (w1) begin
                map_q[rif.dest_arch_1] <= tag_1;
            end
            if (w2) begin
                map_q[rif.dest_arch_2] <= tag_2;
            end
        end
    end
endmodule

// File: tb/tb_rat.sv
// Self-checking bench for rat: directed test-plan steps, then random traffic
// checked against a sequential rename model (slot 1 then slot 2 on a map copy).
module tb_rat;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    rat_if bus ();

    rat dut (
        .clock (clock),
        .reset (reset),
        .rif   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [5:0] mm  [32];
    logic [5:0] nxt [32];
    logic [5:0] e_sa1, e_sb1, e_sa2, e_sb2;
    logic [5:0] e_d1, e_d2, e_o1, e_o2;
    logic       e_u1, e_u2;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rename as if the two instructions were processed one after another.
    task automatic model_eval();
        logic [5:0] tmp [32];
        logic [5:0] pool [2];
        int         k;
        logic       en1, en2, ok;
        ok  = !bus.stall && !bus.flush && !reset;
        en1 = bus.inst_valid_1 && bus.dest_valid_1 &&
              bus.dest_arch_1 != 5'd31 && ok;
        en2 = bus.inst_valid_2 && bus.dest_valid_2 &&
              bus.dest_arch_2 != 5'd31 && ok;
        tmp = mm;
        pool[0] = bus.free_reg_1;
        pool[1] = bus.free_reg_2;
        k = 0;
        e_sa1 = tmp[bus.src_a_arch_1];
        e_sb1 = tmp[bus.src_b_arch_1];
        e_o1  = tmp[bus.dest_arch_1];
        e_d1  = 6'd0;
        if (en1) begin
            e_d1 = pool[k];
            k++;
            tmp[bus.dest_arch_1] = e_d1;
        end
        e_sa2 = tmp[bus.src_a_arch_2];
        e_sb2 = tmp[bus.src_b_arch_2];
        e_o2  = tmp[bus.dest_arch_2];
        e_d2  = 6'd0;
        if (en2) begin
            e_d2 = pool[k];
            tmp[bus.dest_arch_2] = e_d2;
        end
        e_u1 = en1;
        e_u2 = en2;
        for (int i = 0; i < 32; i++) begin
            if (reset) nxt[i] = 6'(i);
            else if (bus.flush) nxt[i] = bus.rrat_prf_out[i];
            else nxt[i] = tmp[i];
        end
    endtask

    task automatic settle(string t);
        model_eval();
        @(negedge clock);
        chk({t, ".used_1"}, bus.used_1, e_u1);
        chk({t, ".used_2"}, bus.used_2, e_u2);
        chk({t, ".src_a_1"}, bus.src_a_tag_1, e_sa1);
        chk({t, ".src_b_1"}, bus.src_b_tag_1, e_sb1);
        chk({t, ".src_a_2"}, bus.src_a_tag_2, e_sa2);
        chk({t, ".src_b_2"}, bus.src_b_tag_2, e_sb2);
        chk({t, ".dest_1"}, bus.dest_tag_1, e_d1);
        chk({t, ".dest_2"}, bus.dest_tag_2, e_d2);
        chk({t, ".old_1"}, bus.old_tag_1, e_o1);
        chk({t, ".old_2"}, bus.old_tag_2, e_o2);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s.map%0d", t, i), bus.rat_map_out[i], mm[i]);
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        mm = nxt;
    endtask

    task automatic idle();
        bus.inst_valid_1 = 0; bus.inst_valid_2 = 0;
        bus.dest_valid_1 = 0; bus.dest_valid_2 = 0;
        bus.dest_arch_1 = 0;  bus.dest_arch_2 = 0;
        bus.src_a_arch_1 = 0; bus.src_b_arch_1 = 0;
        bus.src_a_arch_2 = 0; bus.src_b_arch_2 = 0;
        bus.stall = 0; bus.flush = 0;
        bus.free_reg_1 = 0; bus.free_reg_2 = 0;
        reset = 0;
    endtask

    task automatic s1(logic iv, logic dv, logic [4:0] d,
                      logic [4:0] a, logic [4:0] b);
        bus.inst_valid_1 = iv; bus.dest_valid_1 = dv;
        bus.dest_arch_1 = d; bus.src_a_arch_1 = a; bus.src_b_arch_1 = b;
    endtask

    task automatic s2(logic iv, logic dv, logic [4:0] d,
                      logic [4:0] a, logic [4:0] b);
        bus.inst_valid_2 = iv; bus.dest_valid_2 = dv;
        bus.dest_arch_2 = d; bus.src_a_arch_2 = a; bus.src_b_arch_2 = b;
    endtask

    function automatic logic [4:0] rarch();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        idle();
        for (int i = 0; i < 32; i++) bus.rrat_prf_out[i] = 6'(i);

        // Reset with a live dispatch: nothing may be allocated.
        reset = 1;
        s1(1, 1, 5'd3, 5'd1, 5'd2);
        s2(1, 1, 5'd4, 5'd1, 5'd2);
        bus.free_reg_1 = 6'd32; bus.free_reg_2 = 6'd33;
        @(negedge clock);
        chk("rst.used_1", bus.used_1, 0);
        chk("rst.used_2", bus.used_2, 0);
        @(posedge clock); #1;
        for (int i = 0; i < 32; i++) mm[i] = 6'(i);
        idle();

        bus.src_a_arch_1 = 5'd5;
        settle("reset");
        chk("reset.tag5", bus.src_a_tag_1, 6'd5);
        advance();

        s1(1, 1, 5'd3, 5'd1, 5'd2);
        s2(1, 1, 5'd4, 5'd3, 5'd2);
        bus.free_reg_1 = 6'd32; bus.free_reg_2 = 6'd33;
        settle("dual");
        chk("dual.dest_1", bus.dest_tag_1, 6'd32);
        chk("dual.dest_2", bus.dest_tag_2, 6'd33);
        chk("dual.old_1", bus.old_tag_1, 6'd3);
        chk("dual.old_2", bus.old_tag_2, 6'd4);
        advance();
        idle();
        settle("dual_after");
        chk("dual.map3", bus.rat_map_out[3], 6'd32);
        chk("dual.map4", bus.rat_map_out[4], 6'd33);
        advance();

        s1(1, 1, 5'd7, 5'd0, 5'd1);
        s2(1, 1, 5'd7, 5'd7, 5'd7);
        bus.free_reg_1 = 6'd40; bus.free_reg_2 = 6'd41;
        settle("bypass");
        chk("byp.src_a_2", bus.src_a_tag_2, 6'd40);
        chk("byp.src_b_2", bus.src_b_tag_2, 6'd40);
        chk("byp.old_2", bus.old_tag_2, 6'd40);
        advance();
        idle();
        settle("bypass_after");
        chk("byp.map7", bus.rat_map_out[7], 6'd41);
        advance();

        s1(1, 0, 5'd8, 5'd1, 5'd1);
        s2(1, 1, 5'd9, 5'd2, 5'd3);
        bus.free_reg_1 = 6'd50; bus.free_reg_2 = 6'd51;
        settle("idle1");
        chk("idle1.used_1", bus.used_1, 0);
        chk("idle1.used_2", bus.used_2, 1);
        chk("idle1.dest_2", bus.dest_tag_2, 6'd50);
        advance();

        idle();
        s1(1, 1, 5'd31, 5'd31, 5'd31);
        s2(1, 1, 5'd31, 5'd31, 5'd0);
        bus.free_reg_1 = 6'd52; bus.free_reg_2 = 6'd53;
        settle("zero");
        chk("zero.used_1", bus.used_1, 0);
        chk("zero.src31", bus.src_a_tag_1, 6'd31);
        advance();

        s1(1, 1, 5'd10, 5'd1, 5'd2);
        s2(1, 1, 5'd11, 5'd1, 5'd2);
        bus.stall = 1;
        settle("stall");
        chk("stall.used_2", bus.used_2, 0);
        advance();

        idle();
        s1(1, 1, 5'd3, 5'd1, 5'd2);
        bus.free_reg_1 = 6'd32; bus.free_reg_2 = 6'd33;
        settle("pre_flush");
        advance();
        for (int i = 0; i < 32; i++) bus.rrat_prf_out[i] = 6'($urandom);
        bus.rrat_prf_out[3] = 6'd3;
        idle();
        s1(1, 1, 5'd5, 5'd3, 5'd3);
        bus.free_reg_1 = 6'd60; bus.free_reg_2 = 6'd61;
        bus.flush = 1;
        settle("flush");
        chk("flush.used_1", bus.used_1, 0);
        advance();
        idle();
        s1(1, 1, 5'd6, 5'd3, 5'd5);
        bus.free_reg_1 = 6'd62; bus.free_reg_2 = 6'd63;
        settle("post_flush");
        chk("flush.map3", bus.rat_map_out[3], 6'd3);
        chk("flush.map5", bus.rat_map_out[5], bus.rrat_prf_out[5]);
        advance();

        for (int n = 0; n < 400; n++) begin
            s1(1'($urandom), 1'($urandom), rarch(), rarch(), rarch());
            s2(1'($urandom), 1'($urandom), rarch(), rarch(), rarch());
            bus.free_reg_1 = 6'($urandom);
            bus.free_reg_2 = bus.free_reg_1 + 6'($urandom_range(1, 63));
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) bus.rrat_prf_out[i] = 6'($urandom);
            end
            settle($sformatf("rnd%0d", n));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
